// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the edge-triggered interrupt controller.
package int_ctrl_pkg;

    localparam int ADDR_W = 27;
    localparam logic [ADDR_W-1:0] VECTOR_BASE = 27'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_e;

    // Index width for an n-line vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set bit wins.
module irq_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     vec_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        valid_o = |vec_i;
        idx_o   = '0;
        // Scan downwards so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latching, masked, lowest-index-first interrupt controller with a
// non-nesting request / acknowledge / return handshake towards the CPU.
module interrupt_controller #(
    parameter int                NUM_IRQ     = 8,
    parameter int                ADDR_W      = int_ctrl_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] VECTOR_BASE = ADDR_W'(int_ctrl_pkg::VECTOR_BASE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               reti,
    output logic               int_req,
    output logic [ADDR_W-1:0]  int_vec,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] in_service
);

    import int_ctrl_pkg::*;

    localparam int IDX_W = idx_width(NUM_IRQ);

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               int_req_q, int_req_d;
    logic [ADDR_W-1:0]  int_vec_q, int_vec_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] sel_onehot;
    logic [NUM_IRQ-1:0] clr;
    logic               ack_fire;
    logic               enc_valid;
    logic [IDX_W-1:0]   enc_idx;

    assign rise     = irq & ~irq_prev_q;
    assign eligible = pending_q & ~mask_q;

    irq_prio_enc #(
        .N     (NUM_IRQ),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec_i   (eligible),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    // Per-line pending logic: a new edge beats the acknowledge clear.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            assign sel_onehot[gi] = (sel_q == IDX_W'(gi));
            assign clr[gi]        = ack_fire & sel_onehot[gi];
            assign pending_d[gi]  = rise[gi] | (pending_q[gi] & ~clr[gi]);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        int_req_d    = int_req_q;
        int_vec_d    = int_vec_q;
        in_service_d = in_service_q;
        ack_fire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    sel_d     = enc_idx;
                    int_vec_d = VECTOR_BASE + ADDR_W'(enc_idx);
                    int_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // Selection and vector stay frozen until the CPU takes them.
                if (int_ack) begin
                    ack_fire     = 1'b1;
                    int_req_d    = 1'b0;
                    in_service_d = sel_onehot;
                    state_d      = SVC;
                end
            end
            SVC: begin
                if (reti) begin
                    in_service_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                int_req_d    = 1'b0;
                in_service_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            // Lines already high at reset release must not look like edges.
            irq_prev_q   <= irq;
            pending_q    <= '0;
            mask_q       <= '1;
            in_service_q <= '0;
            sel_q        <= '0;
            int_req_q    <= 1'b0;
            int_vec_q    <= VECTOR_BASE;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            sel_q        <= sel_d;
            int_req_q    <= int_req_d;
            int_vec_q    <= int_vec_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    assign int_req    = int_req_q;
    assign int_vec    = int_vec_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level reference model of the interrupt controller.
module tb_interrupt_controller;

    localparam int             N  = 8;
    localparam int             AW = 27;
    localparam logic [AW-1:0]  VB = 27'd1;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic          int_ack;
    logic          reti;
    logic          int_req;
    logic [AW-1:0] int_vec;
    logic [N-1:0]  pending;
    logic [N-1:0]  mask;
    logic [N-1:0]  in_service;

    always #5 clk = ~clk;

    interrupt_controller #(
        .NUM_IRQ     (N),
        .ADDR_W      (AW),
        .VECTOR_BASE (VB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .reti       (reti),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .pending    (pending),
        .mask       (mask),
        .in_service (in_service)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a request is "outstanding" for line m_line with
    // vector m_vec, and m_svc holds the line in service (-1 if none).
    logic [N-1:0]  m_prev, m_pend, m_mask;
    bit            m_req;
    int            m_line;
    int            m_svc;
    logic [AW-1:0] m_vec;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model and DUT, compare every output.
    task automatic step(input logic r, input logic [N-1:0] irq_v, input logic mwe,
                        input logic [N-1:0] mwd, input logic ack, input logic rt);
        logic [N-1:0]  rise, elig, n_pend, n_mask, n_prev;
        bit            n_req, found;
        int            n_line, n_svc, first;
        logic [AW-1:0] n_vec;
        reset = r; irq = irq_v; mask_we = mwe; mask_wdata = mwd; int_ack = ack; reti = rt;
        n_req = m_req; n_line = m_line; n_svc = m_svc; n_vec = m_vec;
        n_prev = irq_v;
        if (r) begin
            n_pend = '0; n_mask = '1; n_req = 0; n_svc = -1; n_line = 0; n_vec = VB;
        end else begin
            rise   = irq_v & ~m_prev;
            elig   = m_pend & ~m_mask;
            n_pend = m_pend;
            if (m_svc >= 0) begin
                if (rt) n_svc = -1;
            end else if (m_req) begin
                if (ack) begin
                    n_pend[m_line] = 1'b0;
                    n_svc = m_line;
                    n_req = 0;
                end
            end else begin
                found = 0; first = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && elig[i]) begin
                        found = 1; first = i;
                    end
                end
                if (found) begin
                    n_req = 1; n_line = first; n_vec = VB + AW'(first);
                end
            end
            n_pend = n_pend | rise;
            n_mask = mwe ? mwd : m_mask;
        end
        @(posedge clk);
        #1;
        m_prev = n_prev; m_pend = n_pend; m_mask = n_mask;
        m_req = n_req; m_line = n_line; m_svc = n_svc; m_vec = n_vec;
        check("int_req", 32'(int_req), 32'(m_req));
        if (m_req) check("int_vec", 32'(int_vec), 32'(m_vec));
        check("pending", 32'(pending), 32'(m_pend));
        check("mask", 32'(mask), 32'(m_mask));
        check("in_service", 32'(in_service), (m_svc >= 0) ? (32'd1 << m_svc) : 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic ack_then_reti();
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [N-1:0] cur_irq, flip;
        reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; reti = 1'b0;
        m_prev = '0; m_pend = '0; m_mask = '1; m_req = 0; m_line = 0; m_svc = -1; m_vec = VB;
        @(negedge clk);

        // Reset values
        step(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        check("rst_mask", 32'(mask), 32'hFF);
        check("rst_vec", 32'(int_vec), 32'(VB));
        check("rst_req", 32'(int_req), 32'd0);

        // Single edge on line 3
        step(1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
        step(1'b0, 8'h08, 1'b0, '0, 1'b0, 1'b0);
        check("t1_req_n1", 32'(int_req), 32'd0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check("t1_req_n2", 32'(int_req), 32'd1);
        check("t1_vec", 32'(int_vec), 32'd4);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("t1_isvc", 32'(in_service), 32'h08);
        check("t1_pend", 32'(pending), 32'h00);
        check("t1_req_ack", 32'(int_req), 32'd0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        check("t1_isvc_ret", 32'(in_service), 32'h00);

        // Simultaneous edges on lines 5 and 2
        step(1'b0, 8'h24, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        check("t2_vec_first", 32'(int_vec), 32'd3);
        ack_then_reti();
        check("t2_req_r1", 32'(int_req), 32'd0);
        idle(1);
        check("t2_req_r2", 32'(int_req), 32'd1);
        check("t2_vec_second", 32'(int_vec), 32'd6);
        ack_then_reti();

        // Masked line still latches; unmask releases it
        step(1'b0, '0, 1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, 8'h01, 1'b0, '0, 1'b0, 1'b0);
        idle(3);
        check("t3_pend0", 32'(pending[0]), 32'd1);
        check("t3_req_masked", 32'(int_req), 32'd0);
        step(1'b0, '0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("t3_req_m1", 32'(int_req), 32'd0);
        idle(1);
        check("t3_req_m2", 32'(int_req), 32'd1);
        check("t3_vec", 32'(int_vec), 32'd1);
        ack_then_reti();

        // Vector frozen in REQ despite a higher-priority edge
        step(1'b0, 8'h10, 1'b0, '0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 8'h02, 1'b0, '0, 1'b0, 1'b0);
        idle(2);
        check("t4_vec_frozen", 32'(int_vec), 32'd5);
        ack_then_reti();
        idle(1);
        check("t4_vec_next", 32'(int_vec), 32'd2);
        ack_then_reti();

        // Edge coinciding with acknowledge of the same line
        step(1'b0, 8'h04, 1'b0, '0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 8'h04, 1'b0, '0, 1'b1, 1'b0);
        check("t5_pend2", 32'(pending[2]), 32'd1);
        check("t5_isvc", 32'(in_service), 32'h04);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(1);
        check("t5_rereq", 32'(int_req), 32'd1);
        check("t5_vec", 32'(int_vec), 32'd3);
        ack_then_reti();

        // Reset while in service, then a stray reti
        step(1'b0, 8'h40, 1'b0, '0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("t6_isvc", 32'(in_service), 32'h40);
        step(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        check("t6_req", 32'(int_req), 32'd0);
        check("t6_isvc_rst", 32'(in_service), 32'h00);
        check("t6_pend", 32'(pending), 32'h00);
        check("t6_mask", 32'(mask), 32'hFF);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle(2);
        check("t6_stray_reti", 32'(int_req), 32'd0);

        // Line held high through reset release is not an edge
        step(1'b1, 8'h01, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 8'h01, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h01, 1'b0, '0, 1'b0, 1'b0);
        check("t7_no_edge", 32'(pending), 32'h00);
        check("t7_no_req", 32'(int_req), 32'd0);

        // Randomized traffic
        cur_irq = 8'h01;
        for (int c = 0; c < 3000; c++) begin
            flip = '0;
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
            cur_irq = cur_irq ^ flip;
            step(($urandom_range(0, 299) == 0), cur_irq,
                 ($urandom_range(0, 19) == 0), N'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
